mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the number of consecutive wait cycles (mem_ready low) before a granted access aborts; legal range 1..255.
REQ-002 clk  input  1  system clock, all state updated on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 i_addr  input  32  fetch address, stable while i_req high.
REQ-006 i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata  output  32  fetched word, valid when i_ack high.
REQ-008 d_req  input  1  data-memory request, held until d_ack.
REQ-009 d_we  input  1  data write enable (1 = store, 0 = load), stable while d_req high.
REQ-010 d_addr  input  32  data address, stable while d_req high.
REQ-011 d_wdata  input  32  store data, stable while d_req high.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  load data, valid when d_ack high.
REQ-014 err  output  1  high together with i_ack or d_ack when the access timed out.
REQ-015 mem_req  output  1  request to the single-port memory.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid when mem_ready high.
REQ-020 mem_ready  input  1  memory completion, sampled only while mem_req high.

Function
REQ-021 The block SHALL implement states IDLE, GNT_I and GNT_D, with a last_grant bit (I or D) and an 8-bit wait counter.
REQ-022 In IDLE, with one eligible request, the block SHALL move to that requester's GNT state on the next edge.
REQ-023 In IDLE, with both requests eligible, the block SHALL grant the requester opposite to last_grant (round robin).
REQ-024 A request SHALL be ineligible in the cycle its own ack is high, so a requester that holds req one cycle past ack is not regranted.
REQ-025 On entry to GNT_x the block SHALL register mem_req=1 and x's address, and for D also d_we and d_wdata; for I, mem_we SHALL be 0 and mem_wdata SHALL hold.
REQ-026 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and stable for the whole GNT state.
REQ-027 In GNT_x, when mem_ready=1, the next edge SHALL return to IDLE, clear mem_req and mem_we, and set x_ack=1 and last_grant=x; for reads it SHALL load mem_rdata into x_rdata.
REQ-028 For stores, d_rdata SHALL hold its previous value.
REQ-029 The minimum latency SHALL be: req first high in cycle 0, mem_req high in cycle 1, mem_ready high in cycle 1, ack high in cycle 2.
REQ-030 Acks SHALL be single-cycle pulses, and i_ack and d_ack SHALL never be high together.
REQ-031 The wait counter SHALL clear on GNT entry and increment on each GNT cycle with mem_ready=0.
REQ-032 When the wait counter reaches TIMEOUT in GNT_x, the next edge SHALL return to IDLE, clear mem_req, pulse x_ack with err=1, set x_rdata=0 and set last_grant=x.
REQ-033 A mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally with err=0.
REQ-034 While in IDLE the block SHALL drive mem_req=0 and mem_we=0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-035 Requests arriving while in GNT state SHALL wait, with no queue beyond the held req lines.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE and last_grant=D, clear the wait counter, and drive mem_req, mem_we, i_ack, d_ack and err to 0.
REQ-037 rst_n low SHALL also clear mem_addr, mem_wdata, i_rdata and d_rdata to 0.
REQ-038 Reset asserted mid-access SHALL abandon the access without any ack.
REQ-039 After rst_n deasserts, the first simultaneous i_req/d_req tie SHALL be granted to I.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x100, mem_ready=1 in cycle 1, mem_rdata=0x00500093 -> mem_addr=0x100 and mem_we=0 in cycle 1; i_ack=1 and i_rdata=0x00500093 in cycle 2.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles; d_ack pulses once; d_rdata is unchanged.
REQ-042 Tie after reset: i_req and d_req rise together -> I is served first, then D; a second tie is served I then D, and a subsequent tie after D service goes to I.
REQ-043 Timeout: TIMEOUT=4, d_req read, mem_ready held 0 -> d_ack=1 with err=1 and d_rdata=0 five cycles after grant; mem_req drops.
REQ-044 Reset mid-access: rst_n pulled low during GNT_D -> mem_req drops without waiting for a clock; no d_ack; after release, IDLE with all outputs 0.
REQ-045 Held req: i_req kept high one cycle past i_ack while d_req is high -> D is granted next, with no duplicate I access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one single-port memory between an
// instruction-fetch port and a data port, with a per-access wait timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic       LG_I        = 1'b0;
    localparam logic       LG_D        = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic        mem_req_q,    mem_req_d;
    logic        mem_we_q,     mem_we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic        i_ack_q,      i_ack_d;
    logic        d_ack_q,      d_ack_d;
    logic        err_q,        err_d;
    logic [31:0] i_rdata_q,    i_rdata_d;
    logic [31:0] d_rdata_q,    d_rdata_d;

    logic        i_elig;
    logic        d_elig;
    logic        gnt_is_d;
    logic        grant_i;

    // A requester is still holding req in its own ack cycle; mask it there
    // so the completed access is not issued a second time.
    assign i_elig   = i_req && !i_ack_q;
    assign d_elig   = d_req && !d_ack_q;
    assign gnt_is_d = (state_q == GNT_D);
    assign grant_i  = i_elig && (!d_elig || (last_grant_q == LG_D));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                if (grant_i) begin
                    state_d    = GNT_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    wait_cnt_d = 8'd0;
                end else if (d_elig) begin
                    state_d     = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wait_cnt_d  = 8'd0;
                end
            end

            GNT_I, GNT_D: begin
                // A ready seen in the timeout cycle still wins over the abort.
                if (mem_ready) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    last_grant_d = gnt_is_d ? LG_D : LG_I;
                    if (gnt_is_d) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    err_d        = 1'b1;
                    last_grant_d = gnt_is_d ? LG_D : LG_I;
                    if (gnt_is_d) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = 32'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LG_D;
            wait_cnt_q   <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, round robin,
// held request, timeout boundaries and asynchronous reset mid-access.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, mem_req}, 32'd0);

        // Tie after reset: I first, then D with I still held one cycle
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        d_wdata = 32'hDEADBEEF;
        step();
        chk("tie1_first_addr", mem_addr, 32'h10);
        chk("tie1_mem_req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        step();
        chk("tie1_i_ack", {30'd0, i_ack, d_ack}, 32'h2);
        chk("tie1_i_rdata", i_rdata, 32'h11111111);
        mem_ready = 1'b0;
        step();
        chk("held_i_grants_d", mem_addr, 32'h20);
        chk("held_i_ack_pulse", {31'd0, i_ack}, 32'd0);
        i_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h22222222;
        step();
        chk("tie1_d_ack", {30'd0, i_ack, d_ack}, 32'h1);
        chk("tie1_d_rdata", d_rdata, 32'h22222222);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("tie1_d_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Second tie after D service: I then D
        i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_addr = 32'h40;
        step();
        chk("tie2_first_addr", mem_addr, 32'h30);
        mem_ready = 1'b1; mem_rdata = 32'h33333333;
        step();
        chk("tie2_i_ack", {30'd0, i_ack, d_ack}, 32'h2);
        mem_ready = 1'b0;
        step();
        chk("tie2_second_addr", mem_addr, 32'h40);
        i_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h44444444;
        step();
        chk("tie2_d_rdata", d_rdata, 32'h44444444);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Third tie after D service goes to I
        i_req = 1'b1; i_addr = 32'h50; d_req = 1'b1; d_addr = 32'h60;
        step();
        chk("tie3_first_addr", mem_addr, 32'h50);
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        step();
        chk("tie3_i_ack", {30'd0, i_ack, d_ack}, 32'h2);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();
        step();

        // Fetch only, minimum latency, req held one cycle past ack
        i_req = 1'b1; i_addr = 32'h100;
        step();
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        chk("fetch_no_early_ack", {31'd0, i_ack}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        step();
        chk("fetch_i_ack", {31'd0, i_ack}, 32'd1);
        chk("fetch_i_rdata", i_rdata, 32'h00500093);
        chk("fetch_err", {31'd0, err}, 32'd0);
        mem_ready = 1'b0;
        step();
        chk("fetch_no_regrant", {31'd0, mem_req}, 32'd0);
        chk("fetch_ack_pulse", {31'd0, i_ack}, 32'd0);
        chk("idle_addr_hold", mem_addr, 32'h100);
        i_req = 1'b0;
        step();

        // Store with three wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        step();
        chk("store_mem_addr", mem_addr, 32'h2000);
        chk("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("store_we_c1", {31'd0, mem_we}, 32'd1);
        step();
        chk("store_we_c2", {30'd0, mem_we, d_ack}, 32'h2);
        step();
        chk("store_we_c3", {30'd0, mem_we, d_ack}, 32'h2);
        step();
        chk("store_we_c4", {30'd0, mem_we, d_ack}, 32'h2);
        mem_ready = 1'b1; mem_rdata = 32'h99999999;
        step();
        chk("store_d_ack", {29'd0, d_ack, err, mem_we}, 32'h4);
        chk("store_d_rdata_hold", d_rdata, 32'h44444444);
        chk("store_mem_req_low", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        step();
        chk("store_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Timeout on a D read: ack with err five cycles after grant
        d_req = 1'b1; d_addr = 32'h3000;
        step();
        chk("to_mem_req", {30'd0, mem_req, mem_we}, 32'h2);
        step(); step(); step();
        chk("to_wait_c4", {30'd0, mem_req, d_ack}, 32'h2);
        step();
        chk("to_wait_c5", {30'd0, mem_req, d_ack}, 32'h2);
        step();
        chk("to_d_ack_err", {29'd0, d_ack, err, mem_req}, 32'h6);
        chk("to_d_rdata_zero", d_rdata, 32'd0);
        d_req = 1'b0;
        step();
        chk("to_ack_pulse", {30'd0, d_ack, err}, 32'd0);

        // Ready in the timeout cycle completes normally
        d_req = 1'b1; d_addr = 32'h3004;
        step(); step(); step(); step();
        step();
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        chk("edge_ready_ack", {30'd0, d_ack, err}, 32'h2);
        chk("edge_ready_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Fetch keeps mem_wdata from the last D access
        i_req = 1'b1; i_addr = 32'h104;
        step();
        chk("fetch_wdata_hold", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1'b1; mem_rdata = 32'h0000A0A0;
        step();
        chk("fetch2_i_rdata", i_rdata, 32'h0000A0A0);
        i_req = 1'b0; mem_ready = 1'b0;
        step();

        // Asynchronous reset during GNT_D
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h12345678;
        step();
        chk("mid_rst_granted", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", {30'd0, mem_req, mem_we}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_rdata", i_rdata | d_rdata | mem_wdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("mid_rst_no_ack", {29'd0, i_ack, d_ack, err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("mid_rst_idle", {27'd0, i_ack, d_ack, err, mem_req, mem_we}, 32'd0);

        // Post-reset tie goes to I again
        i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_addr = 32'h600;
        step();
        chk("rst_tie_addr", mem_addr, 32'h500);
        mem_ready = 1'b1; mem_rdata = 32'h77777777;
        step();
        chk("rst_tie_i_ack", {30'd0, i_ack, d_ack}, 32'h2);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
